axi4_lite_master_adaptor: RTL

Single-outstanding AXI4-Lite master that converts a simple valid/ready command/response port into AXI4-Lite write (AW/W/B) and read (AR/R) channel traffic. It is the initiator counterpart of the AXI4-Lite slave adaptor and drives it directly in the RTL-master/RTL-slave example bench. Each command produces exactly one AXI transaction and one response beat.

---
 rtl/axi4_lite_master_adaptor_if.sv | 41 ++++
 rtl/axi4_lite_master_adaptor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_adaptor_if.sv
// AXI4-Lite channel bundle between axi4_lite_master_adaptor (master modport) and an AXI4-Lite slave.
interface axi4_lite_master_adaptor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr_out;
  logic [2:0]              awprot_out;
  logic                    awvalid_out;
  logic                    awready_in;
  logic [DATA_WIDTH-1:0]   wdata_out;
  logic [DATA_WIDTH/8-1:0] wstrb_out;
  logic                    wvalid_out;
  logic                    wready_in;
  logic [1:0]              bresp_in;
  logic                    bvalid_in;
  logic                    bready_out;
  logic [ADDR_WIDTH-1:0]   araddr_out;
  logic [2:0]              arprot_out;
  logic                    arvalid_out;
  logic                    arready_in;
  logic [DATA_WIDTH-1:0]   rdata_in;
  logic [1:0]              rresp_in;
  logic                    rvalid_in;
  logic                    rready_out;

  modport master (
    output awaddr_out, awprot_out, awvalid_out, input awready_in,
    output wdata_out, wstrb_out, wvalid_out, input wready_in,
    input bresp_in, bvalid_in, output bready_out,
    output araddr_out, arprot_out, arvalid_out, input arready_in,
    input rdata_in, rresp_in, rvalid_in, output rready_out
  );

  modport slave (
    input awaddr_out, awprot_out, awvalid_out, output awready_in,
    input wdata_out, wstrb_out, wvalid_out, output wready_in,
    output bresp_in, bvalid_in, input bready_out,
    input araddr_out, arprot_out, arvalid_out, output arready_in,
    output rdata_in, rresp_in, rvalid_in, input rready_out
  );
endinterface

// File: rtl/axi4_lite_master_adaptor.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out.
// Optional watchdog enabled by defining AXI4_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_master_adaptor #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       cmd_valid_in,
  output logic                       cmd_ready_out,
  input  logic                       cmd_write_in,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr_in,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata_in,
  input  logic [DATA_WIDTH/8-1:0]    cmd_wstrb_in,
  input  logic [2:0]                 cmd_prot_in,
  output logic                       rsp_valid_out,
  input  logic                       rsp_ready_in,
  output logic                       rsp_write_out,
  output logic [DATA_WIDTH-1:0]      rsp_rdata_out,
  output logic [1:0]                 rsp_resp_out,
  output logic                       rsp_timeout_out,
  axi4_lite_master_adaptor_if.master axi
);

  if (ADDR_WIDTH != 32 || DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axi4_lite_master_adaptor: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                  state, state_next;
  logic                    aw_done, w_done;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [2:0]              prot_q;
  logic                    cmd_fire, aw_fire, w_fire;
  logic                    timeout_hit, timeout_take;

  assign axi.awaddr_out = addr_q;
  assign axi.araddr_out = addr_q;
  assign axi.awprot_out = prot_q;
  assign axi.arprot_out = prot_q;
  assign axi.wdata_out  = wdata_q;
  assign axi.wstrb_out  = wstrb_q;

  assign cmd_fire = cmd_valid_in && cmd_ready_out;
  assign aw_fire  = axi.awvalid_out && axi.awready_in;
  assign w_fire   = axi.wvalid_out && axi.wready_in;

  // Valids come only from state and done flags, never from the matching ready.
  always_comb begin
    state_next      = state;
    cmd_ready_out   = 1'b0;
    axi.awvalid_out = 1'b0;
    axi.wvalid_out  = 1'b0;
    axi.bready_out  = 1'b0;
    axi.arvalid_out = 1'b0;
    axi.rready_out  = 1'b0;
    rsp_valid_out   = 1'b0;
    timeout_take    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_out = !areset;
        if (cmd_valid_in && !areset) state_next = cmd_write_in ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        axi.awvalid_out = !aw_done;
        axi.wvalid_out  = !w_done;
        if ((aw_done || axi.awready_in) && (w_done || axi.wready_in)) begin
          state_next = WR_RESP;
        end else if (timeout_hit) begin
          state_next   = RSP;
          timeout_take = 1'b1;
        end
      end
      WR_RESP: begin
        axi.bready_out = 1'b1;
        if (axi.bvalid_in) begin
          state_next = RSP;
        end else if (timeout_hit) begin
          state_next   = RSP;
          timeout_take = 1'b1;
        end
      end
      RD_REQ: begin
        axi.arvalid_out = 1'b1;
        if (axi.arready_in) begin
          state_next = RD_DATA;
        end else if (timeout_hit) begin
          state_next   = RSP;
          timeout_take = 1'b1;
        end
      end
      RD_DATA: begin
        axi.rready_out = 1'b1;
        if (axi.rvalid_in) begin
          state_next = RSP;
        end else if (timeout_hit) begin
          state_next   = RSP;
          timeout_take = 1'b1;
        end
      end
      RSP: begin
        rsp_valid_out = 1'b1;
        if (rsp_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      prot_q        <= '0;
      rsp_write_out <= 1'b0;
      rsp_rdata_out <= '0;
      rsp_resp_out  <= 2'b00;
    end else begin
      state <= state_next;
      if (cmd_fire) begin
        addr_q        <= cmd_addr_in;
        wdata_q       <= cmd_wdata_in;
        wstrb_q       <= cmd_wstrb_in;
        prot_q        <= cmd_prot_in;
        rsp_write_out <= cmd_write_in;
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire) w_done <= 1'b1;
      if (state == WR_RESP && axi.bvalid_in) begin
        rsp_resp_out  <= axi.bresp_in;
        rsp_rdata_out <= '0;
      end
      if (state == RD_DATA && axi.rvalid_in) begin
        rsp_resp_out  <= axi.rresp_in;
        rsp_rdata_out <= axi.rdata_in;
      end
      if (timeout_take) begin
        rsp_resp_out  <= 2'b10;
        rsp_rdata_out <= '0;
      end
    end
  end

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_count;
  logic          timeout_q;

  // Counter is zero in the first cycle of a request state, so the limit is hit after TIMEOUT_CYCLES cycles.
  always_ff @(posedge aclk) begin
    if (areset || state == IDLE) begin
      wait_count <= '0;
    end else if (state != RSP) begin
      wait_count <= wait_count + CW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset || cmd_fire) begin
      timeout_q <= 1'b0;
    end else if (timeout_take) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_hit     = (state != IDLE) && (state != RSP) && (wait_count == LIMIT);
  assign rsp_timeout_out = timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign rsp_timeout_out = 1'b0;
`endif

endmodule
